// File: rtl/alu32_seq_unit.sv
// Sequential ALU stage: single-cycle logic/arith ops plus a WIDTH-cycle shift-add unsigned
// multiply. One adder serves ADD/SUB/SLT in IDLE and the partial-product accumulate in MUL.
module alu32_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_MULT = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH-1:0]   add_x, add_y;
  logic               add_cin;
  logic [WIDTH:0]     sum;
  logic               add_ovf;
  logic [WIDTH-1:0]   alu_res;
  logic [2*WIDTH-1:0] prod_next;

  // Shared adder: operands come from the ports in IDLE, from the accumulator in MUL.
  always_comb begin
    add_x   = a;
    add_y   = (op == OP_ADD) ? b : ~b;
    add_cin = (op != OP_ADD);
    if (state_q == S_MUL) begin
      add_x   = prod_q[2*WIDTH-1:WIDTH];
      add_y   = prod_q[0] ? mcand_q : '0;
      add_cin = 1'b0;
    end
    sum       = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    add_ovf   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
    prod_next = {sum, prod_q[WIDTH-1:1]};
  end

  // SLT takes the true sign of a-b: the raw sign bit flipped when the subtraction overflowed.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_XOR:  alu_res = a ^ b;
      OP_ADD,
      OP_SUB:  alu_res = sum[WIDTH-1:0];
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MULT) begin
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_MUL;
          end else begin
            res_d  = alu_res;
            hi_d   = '0;
            zero_d = (alu_res == '0);
            ovf_d  = ((op == OP_ADD) || (op == OP_SUB)) && add_ovf;
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        prod_d = prod_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d   = prod_next[WIDTH-1:0];
          hi_d    = prod_next[2*WIDTH-1:WIDTH];
          zero_d  = (prod_next[WIDTH-1:0] == '0);
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;
  assign hi   = hi_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_alu32_seq_unit.sv
// Directed bench for alu32_seq_unit: hand-computed vectors for each op class, multiply timing,
// reset abort and back-to-back issue.
module tb_alu32_seq_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, zero, ovf;
  logic [31:0] res, hi;

  int errors = 0;
  int checks = 0;

  alu32_seq_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .res(res), .hi(hi), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one start for one edge, then scramble the inputs to show they are not used later.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 3'($urandom_range(0, 6)); a = $urandom; b = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res: got %h want 00000000", res); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    checks++; if ({zero, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {zero, ovf}); end
    $display("reset: busy=%b done=%b res=%h hi=%h", busy, done, res, hi);
  endtask

  task automatic test_logic();
    do_op(3'b010, 32'h0F0F0000, 32'h00FF00F0);
    $display("NOR: done=%b res=%h hi=%h zero=%b", done, res, hi, zero);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL nor_done: got %b want 1", done); end
    checks++; if (res !== 32'hF000FF0F) begin errors++; $display("FAIL nor_res: got %h want F000FF0F", res); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL nor_hi: got %h want 00000000", hi); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL nor_zero: got %b want 0", zero); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL nor_done_pulse: got %b want 0", done); end
    checks++; if (res !== 32'hF000FF0F) begin errors++; $display("FAIL nor_hold: got %h want F000FF0F", res); end
    do_op(3'b000, 32'hF0F0F0F0, 32'h0FF00FF0);
    $display("AND: done=%b res=%h", done, res);
    checks++; if (res !== 32'h00F000F0) begin errors++; $display("FAIL and_res: got %h want 00F000F0", res); end
    do_op(3'b001, 32'hF0F0F0F0, 32'h0FF00FF0);
    $display("OR: done=%b res=%h", done, res);
    checks++; if (res !== 32'hFFF0FFF0) begin errors++; $display("FAIL or_res: got %h want FFF0FFF0", res); end
    do_op(3'b011, 32'hF0F0F0F0, 32'h0FF00FF0);
    $display("XOR: done=%b res=%h", done, res);
    checks++; if (res !== 32'hFF00FF00) begin errors++; $display("FAIL xor_res: got %h want FF00FF00", res); end
  endtask

  task automatic test_add_sub();
    do_op(3'b100, 32'h7FFFFFFF, 32'h00000001);
    $display("ADD: done=%b res=%h ovf=%b zero=%b", done, res, ovf, zero);
    checks++; if (res !== 32'h80000000) begin errors++; $display("FAIL add_res: got %h want 80000000", res); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL add_ovf: got %b want 1", ovf); end
    do_op(3'b101, 32'd5, 32'd5);
    $display("SUB: done=%b res=%h ovf=%b zero=%b", done, res, ovf, zero);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL sub_res: got %h want 00000000", res); end
    checks++; if ({zero, ovf} !== 2'b10) begin errors++; $display("FAIL sub_flags: got zero,ovf=%b want 10", {zero, ovf}); end
    do_op(3'b101, 32'h80000000, 32'h00000001);
    $display("SUB: done=%b res=%h ovf=%b", done, res, ovf);
    checks++; if ({res, ovf} !== {32'h7FFFFFFF, 1'b1}) begin errors++; $display("FAIL sub_wrap: got %h/%b want 7FFFFFFF/1", res, ovf); end
    do_op(3'b100, 32'hFFFFFFFF, 32'h00000001);
    $display("ADD: done=%b res=%h ovf=%b zero=%b", done, res, ovf, zero);
    checks++; if ({res, zero, ovf} !== {32'h0, 1'b1, 1'b0}) begin errors++; $display("FAIL add_carry: got %h/%b%b want 00000000/10", res, zero, ovf); end
  endtask

  task automatic test_slt();
    do_op(3'b110, 32'hFFFFFFFF, 32'h00000001);
    $display("SLT: done=%b res=%h", done, res);
    checks++; if (res !== 32'd1) begin errors++; $display("FAIL slt_neg: got %h want 00000001", res); end
    do_op(3'b110, 32'h00000001, 32'hFFFFFFFF);
    $display("SLT: done=%b res=%h", done, res);
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL slt_pos: got %h want 00000000", res); end
    do_op(3'b110, 32'h80000000, 32'h7FFFFFFF);
    $display("SLT: done=%b res=%h ovf=%b", done, res, ovf);
    checks++; if (res !== 32'd1) begin errors++; $display("FAIL slt_ovf: got %h want 00000001", res); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL slt_ovf_flag: got %b want 0", ovf); end
  endtask

  task automatic test_mult();
    int edges;
    int busy_cnt;
    do_op(3'b100, 32'h7FFFFFFF, 32'h00000001);  // leave ovf=1 so MULT must clear it
    start = 1'b1; op = 3'b111; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    tick();
    start = 1'b0; a = 32'h0; b = 32'h0;
    edges = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < 40) begin
      start = (edges == 5 || edges == 20);  // stray AND requests while busy
      op = 3'b000;
      tick();
      edges++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    $display("MULT: edges=%0d busy_cycles=%0d done=%b hi=%h res=%h", edges, busy_cnt, done, hi, res);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_timeout: got done=%b want 1", done); end
    checks++; if (edges !== 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", edges); end
    checks++; if (busy_cnt !== 32) begin errors++; $display("FAIL mult_busy_len: got %0d want 32", busy_cnt); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_hi: got %h want FFFFFFFE", hi); end
    checks++; if (res !== 32'h00000001) begin errors++; $display("FAIL mult_lo: got %h want 00000001", res); end
    checks++; if ({busy, zero, ovf} !== 3'b000) begin errors++; $display("FAIL mult_flags: got busy,zero,ovf=%b want 000", {busy, zero, ovf}); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_extra_done: got %b want 0", done); end
    do_op(3'b111, 32'h12345678, 32'h00000010);
    edges = 1;
    while (!done && edges < 40) begin
      tick();
      edges++;
    end
    $display("MULT: edges=%0d done=%b hi=%h res=%h", edges, done, hi, res);
    checks++; if ({done, hi, res} !== {1'b1, 32'h00000001, 32'h23456780}) begin errors++; $display("FAIL mult2: got %b/%h/%h want 1/00000001/23456780", done, hi, res); end
  endtask

  task automatic test_reset_mid_mul();
    do_op(3'b111, 32'd3, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("abort: busy=%b done=%b res=%h hi=%h", busy, done, res, hi);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_ctl: got busy,done=%b want 00", {busy, done}); end
    checks++; if ({res, hi} !== 64'h0) begin errors++; $display("FAIL abort_data: got %h/%h want 0/0", res, hi); end
    do_op(3'b100, 32'd2, 32'd2);
    $display("ADD after reset: done=%b res=%h", done, res);
    checks++; if ({done, res} !== {1'b1, 32'd4}) begin errors++; $display("FAIL abort_add: got %b/%h want 1/00000004", done, res); end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) break;
    end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_stale_done: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; op = 3'b100; a = 32'd1;
    for (int i = 0; i < 4; i++) begin
      b = i;
      tick();
      $display("b2b ADD 1+%0d: done=%b res=%h", i, done, res);
      checks++; if ({done, res} !== {1'b1, 32'(1 + i)}) begin errors++; $display("FAIL b2b_%0d: got %b/%h want 1/%h", i, done, res, 32'(1 + i)); end
    end
    start = 1'b0;
    tick();
    checks++; if ({done, res} !== {1'b0, 32'd4}) begin errors++; $display("FAIL b2b_end: got %b/%h want 0/00000004", done, res); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_logic();
    test_add_sub();
    test_slt();
    test_mult();
    test_reset_mid_mul();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
